// File: rtl/max_tree_tracker.sv
// Pipelined signed-max tree over N_IN lanes with argmax, feeding a running
// best-score tracker (score, lane, column) with end-of-alignment done pulse.

module max_tree_node #(
   parameter int DW = 16,
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] a_val,
   input  logic [IW-1:0] a_idx,
   input  logic [DW-1:0] b_val,
   input  logic [IW-1:0] b_idx,
   output logic [DW-1:0] q_val,
   output logic [IW-1:0] q_idx
);
   // 'a' is always the lower-lane subtree, so ties resolve to 'a'.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_val <= '0;
         q_idx <= '0;
      end else if (en) begin
         if ($signed(b_val) > $signed(a_val)) begin
            q_val <= b_val;
            q_idx <= b_idx;
         end else begin
            q_val <= a_val;
            q_idx <= a_idx;
         end
      end
   end
endmodule

module max_tree_tracker #(
   parameter int DATA_WIDTH = 16,
   parameter int N_IN       = 8,
   parameter int COL_WIDTH  = 16,
   parameter int FLOOR_ZERO = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         in_valid,
   input  logic [N_IN*DATA_WIDTH-1:0]   in_data,
   input  logic                         in_last,
   output logic                         tree_valid,
   output logic [DATA_WIDTH-1:0]        tree_max,
   output logic [$clog2(N_IN)-1:0]      tree_idx,
   output logic [DATA_WIDTH-1:0]        best_score,
   output logic [$clog2(N_IN)-1:0]      best_lane,
   output logic [COL_WIDTH-1:0]         best_col,
   output logic                         done
);
   localparam int L  = $clog2(N_IN);
   localparam int IW = L;
   localparam int P  = 1 << L;
   localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] BEST_RST = (FLOOR_ZERO != 0) ? '0 : MIN_VAL;
   localparam logic [COL_WIDTH-1:0]  COL_MAX  = '1;

   // Heap-ordered tree: node 1 is the root, leaves occupy P..2P-1.
   logic [DATA_WIDTH-1:0] nval [1:2*P-1];
   logic [IW-1:0]         nidx [1:2*P-1];
   logic [L:0]            vld_pipe;
   logic [L:0]            last_pipe;

   assign vld_pipe[0]  = in_valid & ~clear;
   assign last_pipe[0] = in_valid & in_last;

   for (genvar i = 0; i < P; i++) begin : g_leaf
      if (i < N_IN) begin : g_real
         assign nval[P+i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
         assign nval[P+i] = MIN_VAL;
      end
      assign nidx[P+i] = IW'(i);
   end

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      for (genvar n = 0; n < (1 << (L-k)); n++) begin : g_node
         localparam int J = (1 << (L-k)) + n;
         max_tree_node #(.DW(DATA_WIDTH), .IW(IW)) u_node (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (vld_pipe[k-1] & ~clear),
            .a_val (nval[2*J]),
            .a_idx (nidx[2*J]),
            .b_val (nval[2*J+1]),
            .b_idx (nidx[2*J+1]),
            .q_val (nval[J]),
            .q_idx (nidx[J])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         vld_pipe[L:1]  <= '0;
         last_pipe[L:1] <= '0;
      end else begin
         vld_pipe[L:1]  <= vld_pipe[L-1:0];
         last_pipe[L:1] <= last_pipe[L-1:0];
      end
   end

   assign tree_valid = vld_pipe[L];
   assign tree_max   = nval[1];
   assign tree_idx   = nidx[1];

   // fin marks a completed alignment; the next folded beat starts fresh.
   logic                  fin;
   logic [COL_WIDTH-1:0]  col_cnt;
   logic [DATA_WIDTH-1:0] base_score;
   logic [IW-1:0]         base_lane;
   logic [COL_WIDTH-1:0]  base_col;
   logic [COL_WIDTH-1:0]  beat_col;
   logic                  better;

   always_comb begin
      base_score = fin ? BEST_RST : best_score;
      base_lane  = fin ? '0 : best_lane;
      base_col   = fin ? '0 : best_col;
      beat_col   = fin ? '0 : col_cnt;
      better     = $signed(tree_max) > $signed(base_score);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         best_score <= BEST_RST;
         best_lane  <= '0;
         best_col   <= '0;
         col_cnt    <= '0;
         fin        <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= tree_valid & last_pipe[L];
         if (tree_valid) begin
            if (better) begin
               best_score <= tree_max;
               best_lane  <= tree_idx;
               best_col   <= beat_col;
            end else begin
               best_score <= base_score;
               best_lane  <= base_lane;
               best_col   <= base_col;
            end
            col_cnt <= (beat_col == COL_MAX) ? beat_col : beat_col + COL_WIDTH'(1);
            fin     <= last_pipe[L];
         end
      end
   end
endmodule

// File: doc/max_tree_tracker.md
Name: max_tree_tracker

Overview:
- Parametrised, pipelined signed-max reduction over N_IN score lanes, with argmax lane index. Successor to the combinational 2/4-input max helpers.
- Feeds a running best-score tracker recording score, lane and column of the alignment maximum.
- Sits after the PE array, consuming one V-score per PE per column beat. Produces the final local-alignment score and end position.

Parameters:
- DATA_WIDTH, 16: score width, two's complement.
- N_IN, 8: number of lanes, >=2, need not be a power of two.
- COL_WIDTH, 16: column counter width.
- FLOOR_ZERO, 1: 1 = best score resets/clears to 0 (local alignment); 0 = resets to most-negative value.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous flush of pipeline and tracker.
- in_valid  input  1  beat valid.
- in_data  input  N_IN*DATA_WIDTH  lane scores; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  1  beat is the final column of the alignment; qualified by in_valid.
- tree_valid  output  1  per-beat reduction result valid.
- tree_max  output  DATA_WIDTH  per-beat maximum.
- tree_idx  output  clog2(N_IN)  lane of per-beat maximum.
- best_score  output  DATA_WIDTH  running maximum.
- best_lane  output  clog2(N_IN)  lane of running maximum.
- best_col  output  COL_WIDTH  column index (0-based beat count) of running maximum.
- done  output  1  one-cycle pulse when the last beat has been folded.

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - all pipeline valids, tree_valid and done to 0;
  - tree_max, tree_idx, best_lane, best_col and the column counter to 0;
  - best_score to 0 if FLOOR_ZERO, else {1'b1, zeros}.
- Reset mid-alignment discards all in-flight beats.
- Comparison:
  - Full signed two's-complement compare.
  - Ties go to the lower lane index, so the result is deterministic.
- Padding:
  - When N_IN is not a power of two, pad lanes to 2^L, L = clog2(N_IN).
  - Pad value is {1'b1, zeros}; pad lanes never win against a real lane of equal value (lower-index tie rule).
- Tree pipeline:
  - L levels, one register stage per level. Each stage carries value, index, valid and last.
  - tree_* outputs are valid exactly L cycles after the in_valid beat.
  - Throughput is 1 beat/cycle; no back-pressure. Gaps in in_valid propagate as bubbles.
- Column counter:
  - Increments on each tree_valid beat and tags that beat.
  - The first beat of an alignment is column 0.
  - Saturates at all-ones; no wrap.
- Tracker update, on the tree_valid beat:
  - If tree_max > best_score (strictly), load best_score, best_lane = tree_idx and best_col = that beat's column.
  - Equal scores keep the earlier position.
- Alignment end:
  - The beat with last set updates the tracker in the same cycle.
  - done pulses the following cycle. best_* are final and held stable until the next beat.
- Auto-restart:
  - The first tree_valid beat after done first re-initialises the tracker (best to reset value, counter to 0), then folds that beat as column 0.
  - No clear is needed between alignments.
- clear:
  - Same effect as reset on pipeline valids, column counter and best_* (tree_max/tree_idx hold).
  - A beat presented on in_valid in the clear cycle is dropped.
  - clear has priority over all updates; done is forced to 0.
- FLOOR_ZERO=1 with all-negative scores: best_score stays 0 and best_lane/best_col stay 0.

Test Plan:
- N_IN=8, single beat, lanes {3,-5,7,7,0,1,2,-1}, last=1 -> after 3 cycles tree_max=7, tree_idx=2; next cycle best_score=7, best_lane=2, best_col=0; done pulses one cycle later.
- N_IN=8, four beats with per-beat max 4, 9, 9, 6; last on beat 4 -> best_score=9, best_col=1 (tie keeps earlier); done exactly once.
- N_IN=5 (padded), lanes {-32768, -3, -3, -7, -1}, FLOOR_ZERO=0 -> tree_max=-1, tree_idx=4, latency 3; best_score=-1.
- FLOOR_ZERO=1, beats all negative, last set -> best_score=0, best_lane=0, best_col=0, done pulses.
- Alignment A ends with best 12; alignment B starts next cycle with max 5 -> best_score=5, best_col=0 (auto-restart). Then clear asserted with a beat in flight -> flushed beat produces no tree_valid; best_score=0.
- Back-to-back beats, then rst_n low for 1 cycle mid-stream -> all outputs at reset values next cycle; no tree_valid from pre-reset beats; counter at 70000 beats saturates at 65535.
